// File: rtl/risc_pkg.sv
// Shared definitions for the fetch front end: FSM encodings and reset defaults.
package risc_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [15:0] NOP_IR_DEF   = 16'h0000;

    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs req/ack reads to imem and feeds the IF/ID register.
module if_fetch_unit
    import risc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF,
    parameter logic [15:0] NOP_IR   = NOP_IR_DEF
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC_out,
    output logic [15:0] PC_plus_out,
    output logic [15:0] IR_out,
    output logic        ifid_write,
    output logic        ifid_flush
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  req_addr_q, req_addr_d;
    logic [15:0]  hold_ir_q, hold_ir_d;
    logic [15:0]  hold_pc_q, hold_pc_d;
    logic         pend_q, pend_d;
    logic [15:0]  cur_addr;

    // Without an outstanding request, S_REQ issues a fresh read for pc this cycle.
    assign cur_addr = pend_q ? req_addr_q : pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_ir_d  = hold_ir_q;
        hold_pc_d  = hold_pc_q;
        pend_d     = pend_q;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        PC_out     = pc_q;
        IR_out     = NOP_IR;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;

        if (!clear) begin
            imem_addr = RESET_PC;
            PC_out    = RESET_PC;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    imem_req  = 1'b1;
                    imem_addr = cur_addr;
                    if (imem_ack) begin
                        pend_d = 1'b0;
                        if (redirect) begin
                            pc_d       = redirect_pc;
                            ifid_flush = 1'b1;
                        end else if (!stall) begin
                            IR_out     = imem_rdata;
                            PC_out     = cur_addr;
                            ifid_write = 1'b1;
                            pc_d       = pc_inc(cur_addr);
                        end else begin
                            hold_ir_d = imem_rdata;
                            hold_pc_d = cur_addr;
                            pc_d      = pc_inc(cur_addr);
                            state_d   = S_HOLD;
                        end
                    end else begin
                        pend_d     = 1'b1;
                        req_addr_d = cur_addr;
                        if (redirect) begin
                            pc_d       = redirect_pc;
                            ifid_flush = 1'b1;
                            state_d    = S_DROP;
                        end else begin
                            ifid_flush = ~stall;
                        end
                    end
                end
                S_HOLD: begin
                    IR_out = hold_ir_q;
                    PC_out = hold_pc_q;
                    if (redirect) begin
                        pc_d       = redirect_pc;
                        ifid_flush = 1'b1;
                        state_d    = S_REQ;
                    end else if (!stall) begin
                        ifid_write = 1'b1;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    imem_req   = 1'b1;
                    imem_addr  = req_addr_q;
                    ifid_flush = redirect | ~stall;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end
                    if (imem_ack) begin
                        pend_d  = 1'b0;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        PC_plus_out = pc_inc(PC_out);
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_ir_q  <= NOP_IR;
            hold_pc_q  <= RESET_PC;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_ir_q  <= hold_ir_d;
            hold_pc_q  <= hold_pc_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a flag-based transaction model and a variable-latency imem.
module tb_if_fetch_unit;

    localparam logic [15:0] RST = 16'hFFFF;
    localparam logic [15:0] NOP = 16'h0013;
    localparam int unsigned NumCycles = 4000;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] PC_out;
    logic [15:0] PC_plus_out;
    logic [15:0] IR_out;
    logic        ifid_write;
    logic        ifid_flush;

    if_fetch_unit #(
        .RESET_PC(RST),
        .NOP_IR  (NOP)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PC_out     (PC_out),
        .PC_plus_out(PC_plus_out),
        .IR_out     (IR_out),
        .ifid_write (ifid_write),
        .ifid_flush (ifid_flush)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Reference model: next fetch address, one outstanding read, stale flag, one-entry buffer.
    logic [15:0] m_pc, m_addr, m_held_ir, m_held_pc;
    bit          m_outstanding, m_stale, m_held;
    bit          e_req, e_write, e_flush;
    logic [15:0] e_addr, e_pc, e_ir, e_pc_plus;
    bit          mem_busy;
    int          wait_left;

    task automatic model_reset();
        m_pc          = RST;
        m_addr        = RST;
        m_held_ir     = NOP;
        m_held_pc     = RST;
        m_outstanding = 1'b0;
        m_stale       = 1'b0;
        m_held        = 1'b0;
    endtask

    initial begin
        model_reset();
        mem_busy  = 1'b0;
        wait_left = 0;
        for (int cyc = 0; cyc < NumCycles; cyc++) begin
            @(posedge clock);
            #1;
            clear       = (cyc < 2 || $urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 10);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);

            // Request side of the model depends only on held state.
            e_req  = !m_held;
            e_addr = m_outstanding ? m_addr : m_pc;

            if (!clear) begin
                mem_busy = 1'b0;
            end else if (e_req && !mem_busy) begin
                mem_busy  = 1'b1;
                wait_left = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
            end
            imem_ack   = clear && e_req && mem_busy && (wait_left == 0);
            imem_rdata = imem_ack ? mem_word(e_addr) : 16'($urandom);
            #3;

            if (!clear) begin
                check_eq("rst_req", {15'd0, imem_req}, 16'd0);
                check_eq("rst_write", {15'd0, ifid_write}, 16'd0);
                check_eq("rst_flush", {15'd0, ifid_flush}, 16'd0);
                check_eq("rst_ir", IR_out, NOP);
                check_eq("rst_pc", PC_out, RST);
                check_eq("rst_pc_plus", PC_plus_out, RST + 16'd1);
                model_reset();
            end else begin
                e_write = 1'b0;
                e_flush = 1'b0;
                e_pc    = 16'h0000;
                e_ir    = NOP;
                if (m_held) begin
                    e_pc = m_held_pc;
                    e_ir = m_held_ir;
                    if (redirect) begin
                        e_flush = 1'b1;
                        m_pc    = redirect_pc;
                        m_held  = 1'b0;
                    end else if (!stall) begin
                        e_write = 1'b1;
                        m_held  = 1'b0;
                    end
                end else if (m_stale) begin
                    e_flush = redirect || !stall;
                    if (redirect) m_pc = redirect_pc;
                    if (imem_ack) begin
                        m_stale       = 1'b0;
                        m_outstanding = 1'b0;
                    end
                end else if (imem_ack) begin
                    m_outstanding = 1'b0;
                    if (redirect) begin
                        e_flush = 1'b1;
                        m_pc    = redirect_pc;
                    end else if (!stall) begin
                        e_write = 1'b1;
                        e_pc    = e_addr;
                        e_ir    = mem_word(e_addr);
                        m_pc    = e_addr + 16'd1;
                    end else begin
                        m_held    = 1'b1;
                        m_held_ir = mem_word(e_addr);
                        m_held_pc = e_addr;
                        m_pc      = e_addr + 16'd1;
                    end
                end else begin
                    m_outstanding = 1'b1;
                    m_addr        = e_addr;
                    if (redirect) begin
                        e_flush = 1'b1;
                        m_pc    = redirect_pc;
                        m_stale = 1'b1;
                    end else begin
                        e_flush = !stall;
                    end
                end

                check_eq("imem_req", {15'd0, imem_req}, {15'd0, e_req});
                if (e_req) check_eq("imem_addr", imem_addr, e_addr);
                check_eq("ifid_write", {15'd0, ifid_write}, {15'd0, e_write});
                check_eq("ifid_flush", {15'd0, ifid_flush}, {15'd0, e_flush});
                if (e_write) begin
                    e_pc_plus = e_pc + 16'd1;
                    check_eq("pc_out", PC_out, e_pc);
                    check_eq("pc_plus_out", PC_plus_out, e_pc_plus);
                    check_eq("ir_out", IR_out, e_ir);
                    check_eq("ir_vs_mem", IR_out, mem_word(PC_out));
                end
            end

            if (imem_ack) mem_busy = 1'b0;
            else if (mem_busy) wait_left--;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
